// File: rtl/msg_detector.sv
// msg_detector: detects the 16-digit hex sequence AAC0FFEEA15A900D in a
// valid-qualified digit stream, with overlap-exact restart, an idle timer
// that abandons stale partial matches, and a saturating match counter.
module msg_detector #(
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       clear,
    output logic [4:0] progress,
    output logic       match,
    output logic       timeout,
    output logic [7:0] match_cnt
);

    // Digit k of the pattern lives in bits [4k+3:4k].
    localparam logic [63:0] PATTERN       = 64'hD009_A51A_EEFF_0CAA;
    localparam logic [3:0]  DIGIT_A       = 4'hA;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(IDLE_TIMEOUT);

    typedef enum logic [3:0] {
        ST_0,  ST_1,  ST_2,  ST_3,  ST_4,  ST_5,  ST_6,  ST_7,
        ST_8,  ST_9,  ST_10, ST_11, ST_12, ST_13, ST_14, ST_15
    } prog_t;

    prog_t       state;
    prog_t       next_state;
    logic        full_hit;
    logic [3:0]  expected;
    logic [15:0] idle_cnt;

    assign progress = {1'b0, state};

    // Next match position for the current digit; only consumed when din_valid is high.
    always_comb begin
        next_state = state;
        full_hit   = 1'b0;
        expected   = PATTERN[{state, 2'b00} +: 4];
        if (din == expected) begin
            if (state == ST_15) begin
                full_hit   = 1'b1;
                next_state = ST_0;
            end else begin
                next_state = prog_t'(state + 4'd1);
            end
        end else if (din == DIGIT_A) begin
            // States 2, 9 and 12 were entered on an A, so a mismatching A leaves "AA" matched.
            next_state = (state == ST_2 || state == ST_9 || state == ST_12) ? ST_2 : ST_1;
        end else begin
            next_state = ST_0;
        end
    end

    // Match progress, idle timer, output pulses and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_0;
            idle_cnt  <= '0;
            match     <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
        end else begin
            match   <= 1'b0;
            timeout <= 1'b0;
            if (din_valid) begin
                state    <= next_state;
                idle_cnt <= '0;
                match    <= full_hit;
            end else if (state == ST_0) begin
                idle_cnt <= '0;
            end else if (idle_cnt + 16'd1 == TIMEOUT_LIMIT) begin
                state    <= ST_0;
                idle_cnt <= '0;
                timeout  <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            // Clear is applied before a coinciding detection is counted.
            if (clear) begin
                match_cnt <= (din_valid && full_hit) ? 8'd1 : 8'd0;
            end else if (din_valid && full_hit && match_cnt != '1) begin
                match_cnt <= match_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_msg_detector.sv
// Self-checking bench for msg_detector: directed scenarios with fixed
// expectations plus a randomized run checked against a history-based model.
module tb_msg_detector;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] progress;
    logic       match;
    logic       timeout;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;

    bit [3:0] pat [16] = '{4'hA, 4'hA, 4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE,
                           4'hA, 4'h1, 4'h5, 4'hA, 4'h9, 4'h0, 4'h0, 4'hD};

    // Reference model: the recent valid digits that still form a pattern prefix.
    bit [3:0] hist [$];
    int m_k = 0;
    int m_idle = 0;
    int m_cnt = 0;
    bit m_match = 1'b0;
    bit m_timeout = 1'b0;

    msg_detector #(.IDLE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .progress  (progress),
        .match     (match),
        .timeout   (timeout),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit full_in_hist();
        if (hist.size() != 16) return 1'b0;
        for (int j = 0; j < 16; j++)
            if (hist[j] != pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Longest suffix of the history (at most 15 digits) that is a pattern prefix.
    function automatic int longest_prefix();
        int n;
        n = (hist.size() < 15) ? hist.size() : 15;
        for (int len = n; len > 0; len--) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < len; j++)
                if (hist[hist.size() - len + j] != pat[j]) ok = 1'b0;
            if (ok) return len;
        end
        return 0;
    endfunction

    task automatic cycle(input bit r, input bit v, input logic [3:0] d, input bit c);
        bit nm;
        bit nt;
        int ncnt;
        int keep;
        @(negedge clk);
        rst = r;
        din_valid = v;
        din = d;
        clear = c;
        nm = 1'b0;
        nt = 1'b0;
        ncnt = m_cnt;
        if (r) begin
            hist.delete();
            m_idle = 0;
            ncnt = 0;
        end else begin
            if (v) begin
                hist.push_back(d);
                if (full_in_hist()) begin
                    nm = 1'b1;
                    hist.delete();
                end else begin
                    keep = longest_prefix();
                    while (hist.size() > keep) void'(hist.pop_front());
                end
                m_idle = 0;
            end else if (hist.size() != 0) begin
                if (m_idle + 1 == TO) begin
                    hist.delete();
                    m_idle = 0;
                    nt = 1'b1;
                end else begin
                    m_idle++;
                end
            end else begin
                m_idle = 0;
            end
            if (c) ncnt = 0;
            if (nm) ncnt = (ncnt == 255) ? 255 : ncnt + 1;
        end
        @(posedge clk);
        #1;
        m_match = nm;
        m_timeout = nt;
        m_cnt = ncnt;
        m_k = hist.size();
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 4'hA, 1'b1);
        checks++; if (progress !== 5'd0) begin errors++; $display("FAIL reset_progress got=%0d exp=0", progress); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", match); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
    endtask

    task automatic test_full_pattern();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, pat[i], 1'b0);
            if (i < 15) begin
                checks++; if (progress !== 5'(i + 1)) begin errors++; $display("FAIL full_progress[%0d] got=%0d exp=%0d", i, progress, i + 1); end
                checks++; if (match !== 1'b0) begin errors++; $display("FAIL full_early_match[%0d] got=%b exp=0", i, match); end
            end
        end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL full_match got=%b exp=1", match); end
        checks++; if (progress !== 5'd0) begin errors++; $display("FAIL full_progress_after got=%0d exp=0", progress); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL full_match_cnt got=%0d exp=1", match_cnt); end
        cycle(1'b0, 1'b0, 4'hx, 1'b0);
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL full_match_pulse got=%b exp=0", match); end
    endtask

    task automatic test_overlap();
        int exp_k;
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 4'hA, 1'b0);
        checks++; if (progress !== 5'd1) begin errors++; $display("FAIL overlap_progress[0] got=%0d exp=1", progress); end
        for (int j = 1; j <= 16; j++) begin
            cycle(1'b0, 1'b1, pat[j - 1], 1'b0);
            exp_k = (j == 16) ? 0 : (j <= 2 ? 2 : j);
            checks++; if (progress !== 5'(exp_k)) begin errors++; $display("FAIL overlap_progress[%0d] got=%0d exp=%0d", j, progress, exp_k); end
        end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL overlap_match got=%b exp=1", match); end
    endtask

    task automatic test_restart();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i <= 8; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        checks++; if (progress !== 5'd9) begin errors++; $display("FAIL restart_before got=%0d exp=9", progress); end
        cycle(1'b0, 1'b1, 4'hA, 1'b0);
        checks++; if (progress !== 5'd2) begin errors++; $display("FAIL restart_after_a got=%0d exp=2", progress); end
        for (int i = 2; i < 16; i++) begin
            cycle(1'b0, 1'b1, pat[i], 1'b0);
            if (i < 15) begin
                checks++; if (progress !== 5'(i + 1)) begin errors++; $display("FAIL restart_progress[%0d] got=%0d exp=%0d", i, progress, i + 1); end
            end
        end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL restart_match got=%b exp=1", match); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL restart_match_cnt got=%0d exp=1", match_cnt); end
    endtask

    task automatic test_idle_timeout();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            cycle(1'b0, 1'b0, 4'hx, 1'b0);
            checks++; if (timeout !== 1'b0 || progress !== 5'd3) begin errors++; $display("FAIL idle_hold[%0d] got=%b/%0d exp=0/3", i, timeout, progress); end
        end
        cycle(1'b0, 1'b0, 4'hx, 1'b0);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL idle_timeout got=%b exp=1", timeout); end
        checks++; if (progress !== 5'd0) begin errors++; $display("FAIL idle_progress got=%0d exp=0", progress); end
        cycle(1'b0, 1'b0, 4'hx, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL idle_pulse got=%b exp=0", timeout); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, 4'hx, 1'b0);
        cycle(1'b0, 1'b1, pat[3], 1'b0);
        checks++; if (timeout !== 1'b0 || progress !== 5'd4) begin errors++; $display("FAIL idle_valid_wins got=%b/%0d exp=0/4", timeout, progress); end
        cycle(1'b0, 1'b0, 4'hx, 1'b0);
        checks++; if (timeout !== 1'b0 || progress !== 5'd4) begin errors++; $display("FAIL idle_restart got=%b/%0d exp=0/4", timeout, progress); end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int n = 0; n < 256; n++)
            for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        checks++; if (match_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", match_cnt); end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL sat_match got=%b exp=1", match); end
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        cycle(1'b0, 1'b1, pat[15], 1'b1);
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL sat_clear_match got=%0d exp=1", match_cnt); end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL sat_clear_pulse got=%b exp=1", match); end
        cycle(1'b0, 1'b1, 4'hA, 1'b1);
        checks++; if (match_cnt !== 8'd0 || progress !== 5'd1) begin errors++; $display("FAIL clear_only got=%0d/%0d exp=0/1", match_cnt, progress); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        checks++; if (progress !== 5'd10) begin errors++; $display("FAIL rstmid_before got=%0d exp=10", progress); end
        cycle(1'b1, 1'b1, pat[10], 1'b0);
        checks++; if (progress !== 5'd0 || match !== 1'b0 || timeout !== 1'b0 || match_cnt !== 8'd0) begin
            errors++; $display("FAIL rstmid_outputs got=%0d/%b/%b/%0d exp=0/0/0/0", progress, match, timeout, match_cnt);
        end
        cycle(1'b0, 1'b1, 4'hA, 1'b0);
        checks++; if (progress !== 5'd1) begin errors++; $display("FAIL rstmid_first_a got=%0d exp=1", progress); end
    endtask

    task automatic test_random();
        int idle_run;
        bit r, v, c;
        logic [3:0] d;
        idle_run = 0;
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 49) == 0);
            if (idle_run > 0) begin
                v = 1'b0;
                idle_run--;
            end else if ($urandom_range(0, 19) == 0) begin
                v = 1'b0;
                idle_run = $urandom_range(1, 6);
            end else begin
                v = ($urandom_range(0, 9) != 0);
            end
            if (!v && $urandom_range(0, 1) == 0) d = 4'hx;
            else if ($urandom_range(0, 9) < 7) d = pat[m_k];
            else d = 4'($urandom);
            cycle(r, v, d, c);
            checks++; if (progress !== 5'(m_k)) begin errors++; $display("FAIL rnd_progress[%0d] got=%0d exp=%0d", n, progress, m_k); end
            checks++; if (match !== m_match) begin errors++; $display("FAIL rnd_match[%0d] got=%b exp=%b", n, match, m_match); end
            checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout[%0d] got=%b exp=%b", n, timeout, m_timeout); end
            checks++; if (match_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_match_cnt[%0d] got=%0d exp=%0d", n, match_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_full_pattern();
        test_overlap();
        test_restart();
        test_idle_timeout();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_detector.md
MSG_DETECTOR -- requirements
Module: msg_detector

Interface
REQ-001 Parameter: IDLE_TIMEOUT, default 255, number of consecutive cycles without din_valid (while a partial match is held) before the partial match is abandoned; legal range 1..65535.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: din  input  4  hex digit under test.
REQ-005 Port: din_valid  input  1  din is sampled only in cycles where this is high.
REQ-006 Port: clear  input  1  synchronous clear of match_cnt only.
REQ-007 Port: progress  output  5  number of pattern digits currently matched, 0..15.
REQ-008 Port: match  output  1  one-cycle pulse, full pattern detected.
REQ-009 Port: timeout  output  1  one-cycle pulse, partial match abandoned by idle timer.
REQ-010 Port: match_cnt  output  8  saturating count of detected patterns.

Function
REQ-011 Fixed pattern P[0..15] = A,A,C,0,F,F,E,E,A,1,5,A,9,0,0,D (hex digits, index 0 first); the block detects this digit sequence in the din_valid stream.
REQ-012 State = progress k (0..15); cycles with din_valid low do not advance or alter k except via the idle timer.
REQ-013 On din_valid with din == P[k] and k < 15: k <- k+1 next cycle.
REQ-014 On din_valid with din == P[15] and k == 15: match = 1 next cycle; k <- 0 (no suffix of P ending in D is a prefix of P).
REQ-015 On din_valid with din != P[k]: k <- 2 if din == A and k in {2, 9, 12} (last matched digit was A); k <- 1 if din == A otherwise; k <- 0 if din != A.
REQ-016 Overlapping detection is exact: REQ-013..015 equal the longest-suffix-that-is-prefix rule; no valid digit is ever skipped.
REQ-017 match latency: asserted in the cycle after the din_valid cycle carrying the final D; high exactly one cycle.
REQ-018 match_cnt increments by 1 in the same cycle match asserts; saturates at 255 and holds.
REQ-019 clear high: match_cnt <- 0; if clear coincides with a match-producing input, match_cnt <- 1 (clear applied first); clear does not affect progress, match or timeout.
REQ-020 Idle timer: 16-bit counter, reset to 0 on any din_valid cycle and whenever k == 0; increments each cycle with din_valid low and k != 0.
REQ-021 When idle counter reaches IDLE_TIMEOUT: k <- 0, counter <- 0, timeout = 1 for one cycle (next cycle).
REQ-022 din_valid in the same cycle the counter would reach IDLE_TIMEOUT: din_valid wins, digit processed per REQ-013..015, no timeout.
REQ-023 All outputs are registered; no combinational path from inputs to outputs.
REQ-024 din value is don't-care when din_valid is low; X on din with din_valid low shall not propagate.

Reset
REQ-025 rst high at a clock edge: progress = 0, match = 0, timeout = 0, match_cnt = 0, idle counter = 0, from the following cycle.
REQ-026 rst has priority over din_valid, clear and timer; reset mid-pattern discards the partial match; the first valid digit after rst deassertion is evaluated from k = 0.

Verification
REQ-027 Reset, then 16 consecutive valid digits A,A,C,0,F,F,E,E,A,1,5,A,9,0,0,D -> progress 1..15 stepwise, match = 1 one cycle after the D, match_cnt = 1, progress = 0.
REQ-028 Valid digits A,A,A,C,... (rest of pattern) -> progress 1,2,2,3,...; match fires after final D (overlap on leading A's).
REQ-029 Pattern prefix up to index 8 (…E,E,A) then A, then C,0,F… -> progress 9 then 2 then 3, 4, ...; match after full pattern completes from the restarted position.
REQ-030 IDLE_TIMEOUT = 4: valid A,A,C then din_valid low 4 cycles -> timeout pulse one cycle, progress 0; repeat with valid on 4th idle cycle -> no timeout.
REQ-031 Drive 256 complete patterns -> match_cnt saturates at 255; assert clear together with the 257th final D -> match_cnt = 1.
REQ-032 Assert rst for one cycle when progress = 10 -> all outputs 0 next cycle; subsequent A counts as progress 1.
